// File: rtl/ramp_counter_pkg.sv
// rtl/ramp_counter_pkg.sv - shared mode and direction encodings for the DAC ramp counter
package ramp_counter_pkg;

    localparam logic [1:0] MODE_UP_SAW = 2'b00;
    localparam logic [1:0] MODE_DN_SAW = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ramp_counter.sv
// rtl/ramp_counter.sv - DAC code generator: up/down sawtooth, triangle or hold
module ramp_counter
    import ramp_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [1:0]           mode_i,
    input  logic [CNT_WIDTH-1:0] max_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 tc_o,
    output logic                 dir_o
);

    localparam logic [CNT_WIDTH-1:0] ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic                 tc_q, tc_d;
    logic                 max_zero;

    assign max_zero = (max_i == ZERO);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= ZERO;
            dir_q <= DIR_UP;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    // dir_q doubles as the triangle UP/DOWN state; saw modes just force it
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            case (mode_i)
                MODE_UP_SAW: begin
                    dir_d = DIR_UP;
                    if (cnt_q >= max_i) begin
                        cnt_d = ZERO;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                MODE_DN_SAW: begin
                    dir_d = DIR_DOWN;
                    if (cnt_q == ZERO) begin
                        cnt_d = max_i;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                MODE_TRI: begin
                    if (dir_q == DIR_UP) begin
                        if (cnt_q >= max_i) begin
                            // peak is shown once: step straight to max-1
                            cnt_d = max_zero ? ZERO : (max_i - ONE);
                            dir_d = DIR_DOWN;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end else begin
                        if (cnt_q == ZERO) begin
                            cnt_d = max_zero ? ZERO : ONE;
                            dir_d = DIR_UP;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_comb begin
        cnt_o = cnt_q;
        tc_o  = tc_q;
        dir_o = dir_q;
    end

endmodule

// File: tb/tb_ramp_counter.sv
// tb/tb_ramp_counter.sv - scoreboard bench for ramp_counter with directed vectors
module tb_ramp_counter;

    typedef struct {
        logic [2:0] cnt;
        logic       tc;
        logic       dir;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       en_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic [2:0] max_i = 3'd0;
    logic       load_i = 1'b0;
    logic [2:0] load_val_i = 3'd0;
    logic [2:0] cnt_o;
    logic       tc_o;
    logic       dir_o;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;

    ramp_counter #(.CNT_WIDTH(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .max_i      (max_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .cnt_o      (cnt_o),
        .tc_o       (tc_o),
        .dir_o      (dir_o)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs and queue the outputs expected after that edge
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [2:0] mx, input logic l, input logic [2:0] lv,
                        input logic [2:0] ec, input logic et, input logic ed,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst_i = r; en_i = e; mode_i = m; max_i = mx; load_i = l; load_val_i = lv;
        x.cnt = ec; x.tc = et; x.dir = ed; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (cnt_o !== x.cnt || tc_o !== x.tc || dir_o !== x.dir) begin
                fails++;
                $display("FAIL %s: got cnt=%0d tc=%0b dir=%0b, expected cnt=%0d tc=%0b dir=%0b",
                         x.name, cnt_o, tc_o, dir_o, x.cnt, x.tc, x.dir);
            end
        end
    end

    initial begin
        // reset then up-saw, max 5
        step(1,0,2'b00,3'd5,0,3'd0, 3'd0,0,0, "reset");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd1,0,0, "up1");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd2,0,0, "up2");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd3,0,0, "up3");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd4,0,0, "up4");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd5,0,0, "up5");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd0,1,0, "up_wrap");
        step(0,1,2'b00,3'd5,0,3'd0, 3'd1,0,0, "up_after_wrap");

        // down-saw, full range
        step(1,1,2'b01,3'd7,0,3'd0, 3'd0,0,0, "dn_reset");
        step(0,1,2'b01,3'd7,0,3'd0, 3'd7,1,1, "dn_wrap0");
        for (int i = 6; i >= 0; i--)
            step(0,1,2'b01,3'd7,0,3'd0, 3'(i),0,1, "dn_count");
        step(0,1,2'b01,3'd7,0,3'd0, 3'd7,1,1, "dn_wrap1");

        // triangle, max 3
        step(1,0,2'b10,3'd3,0,3'd0, 3'd0,0,0, "tri_reset");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,0,0, "tri_u1");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,0,0, "tri_u2");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd3,0,0, "tri_peak");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,1,1, "tri_turn_dn");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,0,1, "tri_d1");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd0,0,1, "tri_floor");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,1,0, "tri_turn_up");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,0,0, "tri_u2b");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd3,0,0, "tri_peak2");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,1,1, "tri_turn_dn2");

        // load beats enable; out-of-range value wraps up-saw
        step(1,0,2'b00,3'd4,0,3'd0, 3'd0,0,0, "ld_reset");
        step(0,1,2'b00,3'd4,0,3'd0, 3'd1,0,0, "ld_c1");
        step(0,1,2'b00,3'd4,0,3'd0, 3'd2,0,0, "ld_c2");
        step(0,0,2'b00,3'd4,1,3'd6, 3'd6,0,0, "load_en0");
        step(0,1,2'b00,3'd4,0,3'd6, 3'd0,1,0, "over_max_wrap");
        step(0,1,2'b00,3'd4,0,3'd6, 3'd1,0,0, "ld_c1b");
        step(1,1,2'b00,3'd4,1,3'd6, 3'd0,0,0, "rst_over_load");

        // triangle UP above max turns down at max-1
        step(0,1,2'b10,3'd3,1,3'd6, 3'd6,0,0, "tri_load6");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,1,1, "tri_over_max");
        // load keeps dir
        step(0,1,2'b10,3'd3,1,3'd5, 3'd5,0,1, "load_keep_dir");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd4,0,1, "tri_dn_over");

        // hold and enable gating
        step(1,0,2'b10,3'd3,0,3'd0, 3'd0,0,0, "hold_reset");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,0,0, "h_u1");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,0,0, "h_u2");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd3,0,0, "h_peak");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,1,1, "h_turn");
        step(0,1,2'b11,3'd3,0,3'd0, 3'd2,0,1, "hold_mode1");
        step(0,1,2'b11,3'd3,0,3'd0, 3'd2,0,1, "hold_mode2");
        step(0,0,2'b10,3'd3,0,3'd0, 3'd2,0,1, "en_low1");
        step(0,0,2'b00,3'd3,0,3'd0, 3'd2,0,1, "en_low2");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,0,1, "resume_dn");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd0,0,1, "resume_floor");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,1,0, "resume_turn");

        // max 0 in every counting mode
        step(1,0,2'b00,3'd0,0,3'd0, 3'd0,0,0, "m0_reset");
        step(0,1,2'b00,3'd0,0,3'd0, 3'd0,1,0, "m0_up1");
        step(0,1,2'b00,3'd0,0,3'd0, 3'd0,1,0, "m0_up2");
        step(0,1,2'b01,3'd0,0,3'd0, 3'd0,1,1, "m0_dn");
        step(0,1,2'b10,3'd0,0,3'd0, 3'd0,1,0, "m0_tri_dn");
        step(0,1,2'b10,3'd0,0,3'd0, 3'd0,1,1, "m0_tri_up");

        // raise max in triangle, reset on the down slope
        step(0,1,2'b10,3'd3,0,3'd0, 3'd1,1,0, "m3_turn_up");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,0,0, "m3_u2");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd3,0,0, "m3_peak");
        step(0,1,2'b10,3'd3,0,3'd0, 3'd2,1,1, "m3_turn_dn");
        step(1,1,2'b10,3'd3,0,3'd0, 3'd0,0,0, "rst_mid_tri");
        step(0,0,2'b10,3'd3,0,3'd0, 3'd0,0,0, "post_rst_idle");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
